// File: rtl/aes_shared_sbox_pkg.sv
// Shared definitions for the time-multiplexed AES S-box: legal parameter sets,
// FSM state encoding and byte-slice width.
package aes_shared_sbox_pkg;

    localparam int BYTE_W = 8;

    localparam int LEGAL_WB_0 = 4;
    localparam int LEGAL_WB_1 = 8;
    localparam int LEGAL_WB_2 = 16;

    localparam int LEGAL_NS_0 = 1;
    localparam int LEGAL_NS_1 = 2;
    localparam int LEGAL_NS_2 = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic bit params_legal(input int wb, input int ns);
        bit wb_ok;
        bit ns_ok;
        wb_ok = (wb == LEGAL_WB_0) || (wb == LEGAL_WB_1) || (wb == LEGAL_WB_2);
        ns_ok = (ns == LEGAL_NS_0) || (ns == LEGAL_NS_1) || (ns == LEGAL_NS_2);
        return wb_ok && ns_ok && ((wb % ns) == 0);
    endfunction

    // Group counter width; a single group still gets one bit.
    function automatic int grp_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aes_shared_sbox_lane.sv
// One combinational AES S-box lane holding the FIPS-197 forward and inverse tables.
module aes_sbox_lane
    import aes_shared_sbox_pkg::*;
(
    input  logic [7:0] in_byte,
    input  logic       inv,
    output logic [7:0] out_byte
);

    // Entry x lives at bits [8*(255-x) +: 8]: row 0 of each table is the MSB end.
    localparam logic [2047:0] FWD_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Table lookup selected by the inverse flag.
    always_comb begin
        out_byte = 8'h00;
        if (inv) begin
            out_byte = INV_TABLE[BYTE_W * (255 - int'(in_byte)) +: BYTE_W];
        end else begin
            out_byte = FWD_TABLE[BYTE_W * (255 - int'(in_byte)) +: BYTE_W];
        end
    end

endmodule

// File: rtl/aes_shared_sbox.sv
// Word-wide AES SubBytes built from NUM_SBOX shared lanes, processing one group
// of NUM_SBOX bytes per cycle with a valid/ready handshake on both sides.
module aes_shared_sbox #(
    parameter int WORD_BYTES = 4,
    parameter int NUM_SBOX   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_inv,
    input  logic [8*WORD_BYTES-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*WORD_BYTES-1:0] out_data
);

    import aes_shared_sbox_pkg::*;

    localparam int N  = WORD_BYTES / NUM_SBOX;
    localparam int GW = grp_width(N);
    localparam int DW = BYTE_W * WORD_BYTES;
    localparam logic [GW-1:0] GRP_LAST = GW'(N - 1);
    localparam logic [GW-1:0] GRP_ONE  = GW'(1);

    if (!params_legal(WORD_BYTES, NUM_SBOX)) begin : g_param_check
        $error("aes_shared_sbox: illegal WORD_BYTES=%0d / NUM_SBOX=%0d", WORD_BYTES, NUM_SBOX);
    end

    state_e          state_q, state_d;
    logic [GW-1:0]   grp_q, grp_d;
    logic [DW-1:0]   data_q, data_d;
    logic            inv_q, inv_d;
    logic [DW-1:0]   res_q, res_d;
    logic [DW-1:0]   out_q, out_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_s;
    logic            accept_s;
    logic [7:0]      lane_in_s  [NUM_SBOX];
    logic [7:0]      lane_out_s [NUM_SBOX];

    for (genvar l = 0; l < NUM_SBOX; l++) begin : g_lane
        aes_sbox_lane u_lane (
            .in_byte  (lane_in_s[l]),
            .inv      (inv_q),
            .out_byte (lane_out_s[l])
        );
    end

    // Ready depends only on state, reset and out_ready, never on in_valid.
    always_comb begin
        in_ready_s = 1'b0;
        if (reset) begin
            in_ready_s = 1'b0;
        end else if (state_q == ST_IDLE) begin
            in_ready_s = 1'b1;
        end else if (state_q == ST_DONE) begin
            in_ready_s = out_ready;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = in_valid && in_ready_s;
    end

    // Route the current byte group of the latched word onto the lanes.
    always_comb begin
        for (int l = 0; l < NUM_SBOX; l++) begin
            lane_in_s[l] = data_q[BYTE_W * (int'(grp_q) * NUM_SBOX + l) +: BYTE_W];
        end
    end

    // Next-state, datapath update and output-register loading.
    always_comb begin
        state_d     = state_q;
        grp_d       = grp_q;
        data_d      = data_q;
        inv_d       = inv_q;
        res_d       = res_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_BUSY;
                    grp_d   = '0;
                    data_d  = in_data;
                    inv_d   = in_inv;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                for (int l = 0; l < NUM_SBOX; l++) begin
                    res_d[BYTE_W * (int'(grp_q) * NUM_SBOX + l) +: BYTE_W] = lane_out_s[l];
                end
                if (grp_q == GRP_LAST) begin
                    state_d     = ST_DONE;
                    out_d       = res_d;
                    out_valid_d = 1'b1;
                end else begin
                    grp_d = grp_q + GRP_ONE;
                end
            end
            ST_DONE: begin
                if (!out_ready) begin
                    out_valid_d = 1'b1;
                end else if (accept_s) begin
                    // Back-to-back: hand off the result and start the next word.
                    state_d = ST_BUSY;
                    grp_d   = '0;
                    data_d  = in_data;
                    inv_d   = in_inv;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grp_d   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grp_q       <= '0;
            data_q      <= '0;
            inv_q       <= 1'b0;
            res_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grp_q       <= grp_d;
            data_q      <= data_d;
            inv_q       <= inv_d;
            res_q       <= res_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_q;

endmodule

// File: tb/tb_aes_shared_sbox.sv
// Directed bench for aes_shared_sbox: 4-byte words with one and two lanes,
// plus an exhaustive 16-byte/four-lane round trip against an algebraic S-box model.
module tb_aes_shared_sbox;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        s_valid  [2];
    logic        s_ready  [2];
    logic        s_inv    [2];
    logic [31:0] s_data   [2];
    logic        s_ovalid [2];
    logic        s_oready [2];
    logic [31:0] s_odata  [2];

    logic         b_valid, b_ready, b_inv, b_ovalid, b_oready;
    logic [127:0] b_data, b_odata;

    aes_shared_sbox #(.WORD_BYTES(4), .NUM_SBOX(1)) u_ns1 (
        .clk(clk), .reset(reset),
        .in_valid(s_valid[0]), .in_ready(s_ready[0]), .in_inv(s_inv[0]), .in_data(s_data[0]),
        .out_valid(s_ovalid[0]), .out_ready(s_oready[0]), .out_data(s_odata[0])
    );

    aes_shared_sbox #(.WORD_BYTES(4), .NUM_SBOX(2)) u_ns2 (
        .clk(clk), .reset(reset),
        .in_valid(s_valid[1]), .in_ready(s_ready[1]), .in_inv(s_inv[1]), .in_data(s_data[1]),
        .out_valid(s_ovalid[1]), .out_ready(s_oready[1]), .out_data(s_odata[1])
    );

    aes_shared_sbox #(.WORD_BYTES(16), .NUM_SBOX(4)) u_ns4 (
        .clk(clk), .reset(reset),
        .in_valid(b_valid), .in_ready(b_ready), .in_inv(b_inv), .in_data(b_data),
        .out_valid(b_ovalid), .out_ready(b_oready), .out_data(b_odata)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] din;
        logic        inv;
        logic [31:0] dout;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] sbox_m [256];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            if (a[7]) a = (a << 1) ^ 8'h1b;
            else      a = a << 1;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] w;
        w = {v, v} << n;
        return w[15:8];
    endfunction

    // Forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
    function automatic logic [7:0] sbox_model(input logic [7:0] x);
        logic [7:0] iv;
        iv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) iv = 8'(y);
        end
        return iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
    endfunction

    task automatic xact_small(input int k, input logic [31:0] din, input logic inv,
                              output logic [31:0] dout, output int lat);
        @(negedge clk);
        s_valid[k] = 1'b1;
        s_data[k]  = din;
        s_inv[k]   = inv;
        @(posedge clk);
        #1;
        s_valid[k] = 1'b0;
        s_data[k]  = ~din;
        s_inv[k]   = ~inv;
        lat = 0;
        while (s_ovalid[k] !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        dout = s_odata[k];
        @(negedge clk);
        s_oready[k] = 1'b1;
        @(posedge clk);
        #1;
        s_oready[k] = 1'b0;
    endtask

    task automatic xact_big(input logic [127:0] din, input logic inv,
                            output logic [127:0] dout, output int lat);
        @(negedge clk);
        b_valid = 1'b1;
        b_data  = din;
        b_inv   = inv;
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        b_data  = ~din;
        b_inv   = ~inv;
        lat = 0;
        while (b_ovalid !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        dout = b_odata;
        @(negedge clk);
        b_oready = 1'b1;
        @(posedge clk);
        #1;
        b_oready = 1'b0;
    endtask

    initial begin
        logic [31:0]  r32;
        logic [127:0] din, dout, exp;
        logic [127:0] fwd_res [16];
        int           lat;
        logic         hold_ok;
        logic         stray;

        vecs[0] = '{din: 32'h00530063, inv: 1'b0, dout: 32'h63ed63fb};
        vecs[1] = '{din: 32'h63ed63fb, inv: 1'b1, dout: 32'h00530063};
        vecs[2] = '{din: 32'hff000063, inv: 1'b1, dout: 32'h7d525200};
        vecs[3] = '{din: 32'h01020304, inv: 1'b0, dout: 32'h7c777bf2};
        vecs[4] = '{din: 32'hffffffff, inv: 1'b0, dout: 32'h16161616};
        vecs[5] = '{din: 32'h00000000, inv: 1'b1, dout: 32'h52525252};

        for (int x = 0; x < 256; x++) sbox_m[x] = sbox_model(8'(x));

        for (int k = 0; k < 2; k++) begin
            s_valid[k] = 1'b0; s_inv[k] = 1'b0; s_data[k] = 32'h0; s_oready[k] = 1'b0;
        end
        b_valid = 1'b0; b_inv = 1'b0; b_data = 128'h0; b_oready = 1'b0;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(s_ready[0]), 128'(1'b0));
        chk("rst_out_valid", 128'(s_ovalid[0]), 128'(1'b0));
        chk("rst_out_data", 128'(s_odata[0]), 128'(32'h0));
        chk("rst_big_ready", 128'(b_ready), 128'(1'b0));
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 128'(s_ready[0]), 128'(1'b1));
        chk("post_rst_big_ready", 128'(b_ready), 128'(1'b1));

        // Table-driven vectors on both 4-byte configurations.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 6; i++) begin
                xact_small(k, vecs[i].din, vecs[i].inv, r32, lat);
                chk($sformatf("vec%0d_ns%0d_data", i, k + 1), 128'(r32), 128'(vecs[i].dout));
                chk($sformatf("vec%0d_ns%0d_lat", i, k + 1), 128'(lat), 128'((k == 0) ? 4 : 2));
            end
        end

        // Backpressure: hold DONE for 10 cycles, then hand off back-to-back.
        @(negedge clk);
        s_valid[0] = 1'b1; s_data[0] = 32'h00530063; s_inv[0] = 1'b0;
        @(posedge clk);
        #1;
        s_valid[0] = 1'b0;
        lat = 0;
        while (s_ovalid[0] !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp_lat", 128'(lat), 128'(4));
        hold_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (s_ovalid[0] !== 1'b1 || s_odata[0] !== 32'h63ed63fb || s_ready[0] !== 1'b0)
                hold_ok = 1'b0;
            s_valid[0] = c[0];
            s_data[0]  = 32'hdeadbeef;
            s_inv[0]   = 1'b1;
        end
        chk("bp_hold", 128'(hold_ok), 128'(1'b1));
        @(negedge clk);
        s_oready[0] = 1'b1;
        s_valid[0]  = 1'b1;
        s_data[0]   = 32'h01020304;
        s_inv[0]    = 1'b0;
        #1;
        chk("b2b_ready", 128'(s_ready[0]), 128'(1'b1));
        @(posedge clk);
        #1;
        s_valid[0] = 1'b0; s_oready[0] = 1'b0; s_data[0] = 32'h0;
        chk("b2b_valid_drop", 128'(s_ovalid[0]), 128'(1'b0));
        chk("b2b_busy_ready", 128'(s_ready[0]), 128'(1'b0));
        lat = 0;
        while (s_ovalid[0] !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("b2b_lat", 128'(lat), 128'(4));
        chk("b2b_data", 128'(s_odata[0]), 128'(32'h7c777bf2));
        @(negedge clk);
        s_oready[0] = 1'b1;
        @(posedge clk);
        #1;
        s_oready[0] = 1'b0;

        // Reset sampled on the second BUSY edge discards the in-flight word.
        @(negedge clk);
        s_valid[0] = 1'b1; s_data[0] = 32'hffffffff; s_inv[0] = 1'b0;
        @(posedge clk);
        #1;
        s_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", 128'(s_ovalid[0]), 128'(1'b0));
        chk("mid_rst_data", 128'(s_odata[0]), 128'(32'h0));
        chk("mid_rst_ready", 128'(s_ready[0]), 128'(1'b0));
        reset = 1'b0;
        #1;
        chk("mid_rst_idle_ready", 128'(s_ready[0]), 128'(1'b1));
        stray = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (s_ovalid[0] !== 1'b0) stray = 1'b1;
        end
        chk("mid_rst_no_output", 128'(stray), 128'(1'b0));
        xact_small(0, 32'h00530063, 1'b0, r32, lat);
        chk("post_rst_data", 128'(r32), 128'(32'h63ed63fb));
        chk("post_rst_lat", 128'(lat), 128'(4));

        // Exhaustive forward pass, checked against the algebraic model.
        for (int j = 0; j < 16; j++) begin
            for (int b = 0; b < 16; b++) begin
                din[8*b +: 8] = 8'(j * 16 + b);
                exp[8*b +: 8] = sbox_m[j * 16 + b];
            end
            xact_big(din, 1'b0, dout, lat);
            fwd_res[j] = dout;
            chk($sformatf("fwd_grp%0d", j), dout, exp);
            chk($sformatf("fwd_lat%0d", j), 128'(lat), 128'(4));
        end

        // Inverse of every forward result must restore the original bytes.
        for (int j = 0; j < 16; j++) begin
            for (int b = 0; b < 16; b++) exp[8*b +: 8] = 8'(j * 16 + b);
            xact_big(fwd_res[j], 1'b1, dout, lat);
            chk($sformatf("inv_grp%0d", j), dout, exp);
            chk($sformatf("inv_lat%0d", j), 128'(lat), 128'(4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
